// File: rtl/cmp_pkg.sv
// Shared result encoding for the unsigned magnitude comparator.
// Holds the 2-bit result codes and the helper that turns cascade flags into a code.
package cmp_pkg;

    typedef logic [1:0] cmp_code_t;

    localparam cmp_code_t CMP_NONE = 2'b00;
    localparam cmp_code_t CMP_GT   = 2'b01;
    localparam cmp_code_t CMP_LT   = 2'b10;
    localparam cmp_code_t CMP_EQ   = 2'b11;

    // The cascade guarantees gt and lt are never both set; gt wins defensively.
    function automatic cmp_code_t cmp_encode(input logic gt, input logic lt);
        cmp_code_t code;
        if (gt) begin
            code = CMP_GT;
        end else if (lt) begin
            code = CMP_LT;
        end else begin
            code = CMP_EQ;
        end
        return code;
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit compare cell: greater, less and equal flags for a single bit pair.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a_bit & ~b_bit;
    assign lt = ~a_bit & b_bit;
    assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/compare_4bit_bitwise.sv
// Registered unsigned magnitude comparator built from an MSB-first cascade of bit cells.
// Produces a GT/LT/EQ code, a per-bit match vector and a valid flag one cycle after the inputs.
module compare_4bit_bitwise
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       o,
    output logic             out_valid,
    output logic [WIDTH-1:0] match
);

    logic [WIDTH-1:0] gt_vec;
    logic [WIDTH-1:0] lt_vec;
    logic [WIDTH-1:0] eq_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        cmp_bit_cell u_cell (
            .a_bit (a[i]),
            .b_bit (b[i]),
            .gt    (gt_vec[i]),
            .lt    (lt_vec[i]),
            .eq    (eq_vec[i])
        );
    end

    // Each stage sees whether a more significant bit already decided the result;
    // only the first differing bit (from the MSB) may set gt or lt.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        logic dec_in;
        logic gt_in;
        logic lt_in;
        logic dec;
        logic gt_out;
        logic lt_out;

        if (i == WIDTH - 1) begin : g_msb
            assign dec_in = 1'b0;
            assign gt_in  = 1'b0;
            assign lt_in  = 1'b0;
        end else begin : g_lower
            assign dec_in = g_chain[i+1].dec;
            assign gt_in  = g_chain[i+1].gt_out;
            assign lt_in  = g_chain[i+1].lt_out;
        end

        assign dec    = dec_in | ~eq_vec[i];
        assign gt_out = gt_in | (~dec_in & gt_vec[i]);
        assign lt_out = lt_in | (~dec_in & lt_vec[i]);
    end

    cmp_code_t code_next;

    assign code_next = cmp_encode(g_chain[0].gt_out, g_chain[0].lt_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o         <= CMP_NONE;
            match     <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            o         <= code_next;
            match     <= eq_vec;
            out_valid <= 1'b1;
        end else begin
            o         <= CMP_NONE;
            match     <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compare_4bit_bitwise.sv
// Self-checking bench for compare_4bit_bitwise: scoreboard of expected results,
// one task per scenario, reference results from integer compares.
module tb_compare_4bit_bitwise;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] o;
    logic       out_valid;
    logic [3:0] match;

    int checks;
    int errors;

    typedef struct packed {
        logic [1:0] o;
        logic [3:0] m;
        logic       v;
    } exp_t;

    exp_t sb[$];

    compare_4bit_bitwise #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .o         (o),
        .out_valid (out_valid),
        .match     (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic v, input logic [3:0] aa, input logic [3:0] bb);
        exp_t e;
        int ia;
        int ib;
        ia = int'(aa);
        ib = int'(bb);
        if (!v) begin
            e.o = 2'b00;
            e.m = 4'b0000;
            e.v = 1'b0;
        end else begin
            if (ia > ib)      e.o = 2'b01;
            else if (ia < ib) e.o = 2'b10;
            else              e.o = 2'b11;
            for (int k = 0; k < 4; k++) e.m[k] = (aa[k] == bb[k]);
            e.v = 1'b1;
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, record its expected result, and stop just after the edge.
    task automatic drive_cycle(input logic v, input logic [3:0] aa, input logic [3:0] bb);
        @(negedge clk);
        in_valid = v;
        a        = aa;
        b        = bb;
        sb.push_back(model(v, aa, bb));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o !== 2'b00 || out_valid !== 1'b0 || match !== 4'b0000) begin
                errors++;
                $display("FAIL reset cycle %0d: got o=%b out_valid=%b match=%b, required o=00 out_valid=0 match=0000",
                         c, o, out_valid, match);
            end
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_exhaustive;
        exp_t e;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                drive_cycle(1'b1, 4'(ia), 4'(ib));
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL exhaustive a=%0d b=%0d: scoreboard empty", ia, ib);
                end else begin
                    e = sb.pop_front();
                    if (o !== e.o || match !== e.m || out_valid !== e.v) begin
                        errors++;
                        $display("FAIL exhaustive a=%0d b=%0d: got o=%b match=%b v=%b, required o=%b match=%b v=%b",
                                 ia, ib, o, match, out_valid, e.o, e.m, e.v);
                    end
                end
            end
        end
    endtask

    task automatic test_examples;
        exp_t e;
        logic [3:0] ta [5] = '{4'd9, 4'd3, 4'd7, 4'b1000, 4'b0111};
        logic [3:0] tb [5] = '{4'd3, 4'd9, 4'd7, 4'b0111, 4'b1000};
        logic [1:0] tc [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, ta[k], tb[k]);
            e = sb.pop_front();
            checks++;
            if (o !== tc[k] || o !== e.o || match !== e.m) begin
                errors++;
                $display("FAIL example/msb a=%b b=%b: got o=%b match=%b, required o=%b match=%b",
                         ta[k], tb[k], o, match, tc[k], e.m);
            end
        end
        drive_cycle(1'b1, 4'b1000, 4'b0111);
        void'(sb.pop_front());
        checks++;
        if (match !== 4'b0000) begin
            errors++;
            $display("FAIL msb_match: got match=%b, required 0000", match);
        end
    endtask

    task automatic test_match;
        exp_t e;
        drive_cycle(1'b1, 4'b1010, 4'b1001);
        e = sb.pop_front();
        checks++;
        if (o !== 2'b01 || match !== 4'b1100 || match !== e.m) begin
            errors++;
            $display("FAIL match_gt: got o=%b match=%b, required o=01 match=1100", o, match);
        end
        drive_cycle(1'b1, 4'b0101, 4'b0101);
        e = sb.pop_front();
        checks++;
        if (o !== 2'b11 || match !== 4'b1111 || match !== e.m) begin
            errors++;
            $display("FAIL match_eq: got o=%b match=%b, required o=11 match=1111", o, match);
        end
    endtask

    task automatic test_valid_gating;
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            drive_cycle((c % 2) == 0, 4'd5, 4'd2);
            e = sb.pop_front();
            checks++;
            if (o !== e.o || out_valid !== e.v || match !== e.m) begin
                errors++;
                $display("FAIL valid_gating cycle %0d: got o=%b v=%b match=%b, required o=%b v=%b match=%b",
                         c, o, out_valid, match, e.o, e.v, e.m);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        drive_cycle(1'b1, 4'd7, 4'd7);
        e = sb.pop_front();
        checks++;
        if (o !== 2'b11) begin
            errors++;
            $display("FAIL async_pre: got o=%b, required 11", o);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o !== 2'b00 || out_valid !== 1'b0 || match !== 4'b0000) begin
            errors++;
            $display("FAIL async_clear: got o=%b v=%b match=%b, required o=00 v=0 match=0000",
                     o, out_valid, match);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 4'd9, 4'd3);
        e = sb.pop_front();
        checks++;
        if (o !== 2'b01 || out_valid !== 1'b1 || match !== e.m) begin
            errors++;
            $display("FAIL async_after: got o=%b v=%b match=%b, required o=01 v=1 match=%b",
                     o, out_valid, match, e.m);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rv;
        for (int c = 0; c < 40; c++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 3) != 0);
            drive_cycle(rv, ra, rb);
            e = sb.pop_front();
            checks++;
            if (o !== e.o || out_valid !== e.v || match !== e.m) begin
                errors++;
                $display("FAIL back_to_back a=%0d b=%0d v=%b: got o=%b v=%b match=%b, required o=%b v=%b match=%b",
                         ra, rb, rv, o, out_valid, match, e.o, e.v, e.m);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        test_reset();
        test_exhaustive();
        test_examples();
        test_match();
        test_valid_gating();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
